// File: rtl/game_score_manager.sv
// game_score_manager: frame-level event stage behind the collision detector.
// Collapses pixel-level collision strobes into per-frame events, runs the
// IDLE/PLAYING/GAME_OVER state machine and maintains score, lives and the
// post-damage immunity counter.
// Optional feature macro: SCORE_BONUS_LIFE_EN (bonus life each BONUS_STEP points).
module game_score_manager #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 7,
  parameter int ENEMY_POINTS  = 10,
  parameter int HD_POINTS     = 25,
  parameter int MAX_SCORE     = 9999,
  parameter int INVULN_FRAMES = 60,
  parameter int BONUS_STEP    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic [2:0]  ShotEnemyCollision,
  input  logic [2:0]  ShotBoxCollision,
  input  logic        ShotHeadsDownCollision,
  input  logic        TowerEnemyHUCollision,
  input  logic        towerPlayerCollision,
  output logic [2:0]  shotKill,
  output logic [2:0]  shotBlocked,
  output logic [13:0] score,
  output logic [2:0]  lives,
  output logic        playing,
  output logic        gameOver,
  output logic        invulnerable
);

  localparam int INV_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAYING,
    S_GAME_OVER
  } state_t;

  state_t           state, state_n;
  logic [INV_W-1:0] inv_cnt, inv_n;
  logic [2:0]       kill_l, kill_n, blk_l, blk_n;
  logic             hd_l, hd_n, dmg_l, dmg_n;
  logic [13:0]      score_n;
  logic [2:0]       lives_n, shot_kill_n, shot_blocked_n;
  logic [15:0]      sum;
  logic [1:0]       kill_cnt;
  logic [3:0]       lives_calc;
  logic             lose, gain;

  // Next-state, frame latch and commit arithmetic
  always_comb begin
    state_n        = state;
    score_n        = score;
    lives_n        = lives;
    inv_n          = inv_cnt;
    kill_n         = '0;
    blk_n          = '0;
    hd_n           = 1'b0;
    dmg_n          = 1'b0;
    shot_kill_n    = '0;
    shot_blocked_n = '0;

    kill_cnt = 2'({1'b0, kill_l[0]}) + 2'({1'b0, kill_l[1]}) + 2'({1'b0, kill_l[2]});
    sum      = 16'(score) + 16'(kill_cnt) * 16'(ENEMY_POINTS)
             + (hd_l ? 16'(HD_POINTS) : 16'd0);
    lose     = dmg_l && (inv_cnt == '0);
`ifdef SCORE_BONUS_LIFE_EN
    // Only a non-saturating commit that lands in a higher BONUS_STEP bucket earns a life
    gain     = (sum <= 16'(MAX_SCORE)) &&
               ((sum / 16'(BONUS_STEP)) != (16'(score) / 16'(BONUS_STEP)));
`else
    gain     = 1'b0;
`endif
    lives_calc = 4'(lives) - 4'(lose) + 4'(gain);
    if (lives_calc > 4'(MAX_LIVES)) lives_calc = 4'(MAX_LIVES);

    case (state)
      S_PLAYING: begin
        if (startOfFrame) begin
          // Commit the finished frame; this cycle's strobes seed the next frame
          score_n        = (sum > 16'(MAX_SCORE)) ? 14'(MAX_SCORE) : sum[13:0];
          lives_n        = lives_calc[2:0];
          shot_kill_n    = kill_l;
          shot_blocked_n = blk_l & ~kill_l;
          if (lose)                inv_n = INV_W'(INVULN_FRAMES);
          else if (inv_cnt != '0)  inv_n = inv_cnt - 1'b1;
          if (lives_calc == 4'd0) begin
            state_n = S_GAME_OVER;
          end else begin
            kill_n = ShotEnemyCollision;
            blk_n  = ShotBoxCollision;
            hd_n   = ShotHeadsDownCollision;
            dmg_n  = towerPlayerCollision | TowerEnemyHUCollision;
          end
        end else begin
          kill_n = kill_l | ShotEnemyCollision;
          blk_n  = blk_l | ShotBoxCollision;
          hd_n   = hd_l | ShotHeadsDownCollision;
          dmg_n  = dmg_l | towerPlayerCollision | TowerEnemyHUCollision;
        end
      end
      default: begin
        if (startGame) begin
          state_n = S_PLAYING;
          score_n = '0;
          lives_n = 3'(START_LIVES);
          inv_n   = '0;
        end
      end
    endcase
  end

  // State, latch and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      score        <= '0;
      lives        <= '0;
      inv_cnt      <= '0;
      kill_l       <= '0;
      blk_l        <= '0;
      hd_l         <= 1'b0;
      dmg_l        <= 1'b0;
      shotKill     <= '0;
      shotBlocked  <= '0;
      playing      <= 1'b0;
      gameOver     <= 1'b0;
      invulnerable <= 1'b0;
    end else begin
      state        <= state_n;
      score        <= score_n;
      lives        <= lives_n;
      inv_cnt      <= inv_n;
      kill_l       <= kill_n;
      blk_l        <= blk_n;
      hd_l         <= hd_n;
      dmg_l        <= dmg_n;
      shotKill     <= shot_kill_n;
      shotBlocked  <= shot_blocked_n;
      playing      <= (state_n == S_PLAYING);
      gameOver     <= (state_n == S_GAME_OVER);
      invulnerable <= (inv_n != '0);
    end
  end

endmodule

// File: tb/tb_game_score_manager.sv
// Directed bench for game_score_manager; expected values computed by hand.
module tb_game_score_manager;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic        sg = 1'b0;
  logic [2:0]  sec = '0;
  logic [2:0]  sbc = '0;
  logic        shd = 1'b0;
  logic        teh = 1'b0;
  logic        tpc = 1'b0;
  logic [2:0]  shot_kill, shot_blocked;
  logic [13:0] score;
  logic [2:0]  lives;
  logic        playing, game_over, invuln;

  int unsigned total = 0;
  int unsigned passed = 0;

`ifdef SCORE_BONUS_LIFE_EN
  localparam int L500 = 4, L2015 = 7, L2510 = 7;
`else
  localparam int L500 = 3, L2015 = 3, L2510 = 3;
`endif

  game_score_manager #(
    .START_LIVES(3), .MAX_LIVES(7), .ENEMY_POINTS(10), .HD_POINTS(25),
    .MAX_SCORE(9999), .INVULN_FRAMES(60), .BONUS_STEP(500)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .startGame(sg),
    .ShotEnemyCollision(sec), .ShotBoxCollision(sbc),
    .ShotHeadsDownCollision(shd), .TowerEnemyHUCollision(teh),
    .towerPlayerCollision(tpc),
    .shotKill(shot_kill), .shotBlocked(shot_blocked), .score(score),
    .lives(lives), .playing(playing), .gameOver(game_over),
    .invulnerable(invuln)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    sof = 1'b1;
    step();
    sof = 1'b0;
  endtask

  task automatic frame(input logic [2:0] k, input logic [2:0] b, input logic hd);
    sec = k; sbc = b; shd = hd;
    step();
    sec = '0; sbc = '0; shd = 1'b0;
    commit();
  endtask

  task automatic dmg_frame();
    tpc = 1'b1; teh = 1'b1;
    step();
    tpc = 1'b0; teh = 1'b0;
    commit();
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_score", score, 0);
    check("rst_lives", lives, 0);
    check("rst_playing", playing, 0);
    check("rst_gameover", game_over, 0);
    check("rst_invuln", invuln, 0);
    check("rst_kill", shot_kill, 0);
    check("rst_blocked", shot_blocked, 0);
    reset = 1'b0;
    step();
    check("idle_playing", playing, 0);

    // Start
    sg = 1'b1; step(); sg = 1'b0;
    check("start_playing", playing, 1);
    check("start_lives", lives, 3);
    check("start_score", score, 0);

    // Multi-cycle enemy hit collapses to one event
    sec = 3'b101;
    repeat (40) step();
    sec = '0;
    commit();
    check("multi_kill", shot_kill, 5);
    check("multi_score", score, 20);
    step();
    check("multi_pulse_end", shot_kill, 0);
    commit();
    check("multi_next_kill", shot_kill, 0);
    check("multi_next_score", score, 20);

    // Collision coincident with startOfFrame belongs to the new frame
    sec = 3'b010; sof = 1'b1; step(); sof = 1'b0; sec = '0;
    check("coinc_kill0", shot_kill, 0);
    check("coinc_score0", score, 20);
    commit();
    check("coinc_kill1", shot_kill, 2);
    check("coinc_score1", score, 30);

    // Kill beats blocked on the same shot
    frame(3'b010, 3'b011, 1'b0);
    check("prio_kill", shot_kill, 2);
    check("prio_blocked", shot_blocked, 1);
    check("prio_score", score, 40);

    // Combined damage, immunity window
    dmg_frame();
    check("dmg_lives", lives, 2);
    check("dmg_invuln", invuln, 1);
    repeat (59) dmg_frame();
    check("immune59_lives", lives, 2);
    check("immune59_invuln", invuln, 1);
    dmg_frame();
    check("immune60_lives", lives, 2);
    check("immune60_invuln", invuln, 0);
    dmg_frame();
    check("dmg61_lives", lives, 1);

    // Game over
    repeat (60) commit();
    check("pre_go_invuln", invuln, 0);
    dmg_frame();
    check("go_lives", lives, 0);
    check("go_flag", game_over, 1);
    check("go_playing", playing, 0);
    frame(3'b111, 3'b000, 1'b1);
    check("go_score_frozen", score, 40);
    check("go_no_kill", shot_kill, 0);

    // Restart
    sg = 1'b1; step(); sg = 1'b0;
    check("re_playing", playing, 1);
    check("re_gameover", game_over, 0);
    check("re_score", score, 0);
    check("re_lives", lives, 3);
    check("re_invuln", invuln, 0);

    // startGame while playing is ignored
    sec = 3'b001; step(); sec = '0;
    sg = 1'b1; step(); sg = 1'b0;
    commit();
    check("ign_start_kill", shot_kill, 1);
    check("ign_start_score", score, 10);

    // Bonus life boundary (score 490 -> 500)
    repeat (8) frame(3'b111, 3'b000, 1'b1);
    frame(3'b111, 3'b000, 1'b0);
    frame(3'b001, 3'b000, 1'b0);
    check("s490_score", score, 490);
    check("s490_lives", lives, 3);
    frame(3'b001, 3'b000, 1'b0);
    check("s500_score", score, 500);
    check("s500_lives", lives, L500);
    repeat (27) frame(3'b111, 3'b000, 1'b1);
    frame(3'b111, 3'b000, 1'b0);
    check("s2015_score", score, 2015);
    check("s2015_lives", lives, L2015);
    repeat (9) frame(3'b111, 3'b000, 1'b1);
    check("s2510_score", score, 2510);
    check("s2510_lives_cap", lives, L2510);

    // Saturation
    repeat (135) frame(3'b111, 3'b000, 1'b1);
    repeat (2) frame(3'b111, 3'b000, 1'b0);
    check("s9995_score", score, 9995);
    frame(3'b001, 3'b000, 1'b1);
    check("sat_score", score, 9999);
    frame(3'b010, 3'b010, 1'b0);
    check("sat_prio_kill", shot_kill, 2);
    check("sat_prio_blocked", shot_blocked, 0);
    check("sat_hold", score, 9999);

    // Back-to-back startOfFrame
    sec = 3'b100; step(); sec = '0;
    sof = 1'b1;
    step();
    check("b2b_kill0", shot_kill, 4);
    step();
    check("b2b_kill1", shot_kill, 0);
    sof = 1'b0;

    // Reset mid-frame
    sec = 3'b111; step();
    reset = 1'b1; step();
    check("mid_rst_score", score, 0);
    check("mid_rst_lives", lives, 0);
    check("mid_rst_playing", playing, 0);
    reset = 1'b0; sec = '0;
    sg = 1'b1; step(); sg = 1'b0;
    commit();
    check("mid_rst_kill", shot_kill, 0);
    check("mid_rst_score2", score, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
